// File: rtl/window_accumulator.sv
// Sums fixed windows of ACC_LEN valid samples, scales by >>>SHIFT, queues results in a 2-entry buffer.
// Result one cycle after the last sample; upstream never stalls, a full buffer drops the result and counts it.

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full buffer is legal when the head leaves on the same edge.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module window_accumulator #(
  parameter int IN_WIDTH  = 20,
  parameter int ACC_LEN   = 16,
  parameter int SHIFT     = 4,
  parameter int OVR_WIDTH = 8,
  localparam int ACC_WIDTH = IN_WIDTH + $clog2(ACC_LEN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  input  logic                        clear,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OVR_WIDTH-1:0]        overrun_count,
  output logic                        busy
);
  localparam int CW = $clog2(ACC_LEN);

  if (ACC_LEN < 2 || (ACC_LEN & (ACC_LEN - 1)) != 0 || SHIFT < 0 || SHIFT > CW) begin : g_bad_params
    $error("window_accumulator: ACC_LEN must be a power of two >= 2 and SHIFT within 0..log2(ACC_LEN)");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state, state_nxt;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt, sample_ext, sum, result;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   push, pop, buf_full, buf_empty, drop;

  assign sample_ext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign sum        = acc + sample_ext;
  assign result     = sum >>> SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    push      = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          acc_nxt   = sample_ext;
          cnt_nxt   = CW'(1);
          state_nxt = ACCUM;
        end
        ACCUM: begin
          if (cnt == CW'(ACC_LEN - 1)) begin
            push      = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            acc_nxt = sum;
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy      = (state == ACCUM);
  assign out_valid = ~buf_empty;
  assign pop       = out_valid & out_ready;
  assign drop      = push & buf_full & ~pop;

  fifo #(.WIDTH(ACC_WIDTH), .DEPTH(2)) u_buf (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .push_dat (result),
    .pop      (pop),
    .pop_dat  (out_data),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_count <= '0;
    end else if (drop && overrun_count != '1) begin
      overrun_count <= overrun_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_window_accumulator.sv
// Scoreboard bench for window_accumulator with ACC_LEN=4, SHIFT=2, IN_WIDTH=20.
// A negedge model predicts each window result and buffer drops; outputs are compared as they are popped.

module tb_window_accumulator;
  localparam int IN_WIDTH  = 20;
  localparam int ACC_LEN   = 4;
  localparam int SHIFT     = 2;
  localparam int OVR_WIDTH = 8;
  localparam int ACC_WIDTH = IN_WIDTH + $clog2(ACC_LEN);

  logic                 clk;
  logic                 reset;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 clear;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OVR_WIDTH-1:0] overrun_count;
  logic                 busy;

  window_accumulator #(
    .IN_WIDTH (IN_WIDTH),
    .ACC_LEN  (ACC_LEN),
    .SHIFT    (SHIFT),
    .OVR_WIDTH(OVR_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .clear        (clear),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun_count(overrun_count),
    .busy         (busy)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint sb[$];
  longint m_acc = 0;
  int     m_cnt = 0;
  int     exp_ovr = 0;
  int     busy_cycles = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got 0, expected 1");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

  // Model and output monitor; inputs change 1 time unit after posedge, so they are stable here.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      m_acc = 0;
      m_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", longint'($signed(out_data)), -999999);
        else check("out_data", longint'($signed(out_data)), sb.pop_front());
      end
      if (busy) busy_cycles++;
      if (clear) begin
        m_acc = 0;
        m_cnt = 0;
      end else if (in_valid) begin
        m_acc += longint'($signed(in_data));
        m_cnt++;
        if (m_cnt == ACC_LEN) begin
          if (sb.size() < 2) sb.push_back(m_acc >>> SHIFT);
          else if (exp_ovr < 255) exp_ovr++;
          m_acc = 0;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic drive(input int v);
    @(posedge clk);
    #1;
    in_data  = IN_WIDTH'(v);
    in_valid = 1'b1;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
    end
  endtask

  task automatic window4(input int a, input int b, input int c, input int d);
    drive(a); drive(b); drive(c); drive(d);
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_count, 0);

    // Basic window, latency and single-cycle valid pulse
    busy_cycles = 0;
    window4(1, 2, 3, 4);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_data", longint'($signed(out_data)), 2);
    @(posedge clk);
    #1;
    check("pulse_one_cycle", out_valid, 0);
    check("busy_cycles", busy_cycles, 3);

    window4(-1, -2, -3, -4);
    idle(2);
    window4(3, 0, 0, 0);
    idle(3);

    // Gaps inside a window
    drive(5); idle(2); drive(6); idle(2); drive(7); idle(2); drive(8);
    idle(3);
    check("gap_busy_idle", busy, 0);

    // Clear after two samples; the sample alongside clear is discarded
    drive(5); drive(6);
    @(posedge clk);
    #1;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = IN_WIDTH'(99);
    idle(1);
    check("busy_after_clear", busy, 0);
    window4(1, 1, 1, 1);
    idle(3);

    // Overrun: buffer holds two results, third is dropped
    out_ready = 1'b0;
    window4(1, 1, 1, 1);
    window4(2, 2, 2, 2);
    window4(3, 3, 3, 3);
    idle(2);
    check("ovr_count", overrun_count, 1);
    check("ovr_model", overrun_count, exp_ovr);
    check("stall_valid", out_valid, 1);
    check("stall_hold_data", longint'($signed(out_data)), 1);
    idle(2);
    check("stall_still_hold", longint'($signed(out_data)), 1);
    out_ready = 1'b1;
    idle(3);
    check("drained_valid", out_valid, 0);
    check("drained_sb", sb.size(), 0);
    check("ovr_sticky", overrun_count, 1);

    // Extremes of the input range
    window4(524287, 524287, 524287, 524287);
    idle(2);
    window4(-524288, -524288, -524288, -524288);
    idle(3);

    // Asynchronous reset mid-window with a buffered result pending
    out_ready = 1'b0;
    window4(1, 1, 1, 1);
    drive(7); drive(7);
    idle(1);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    window4(8, 8, 8, 8);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("post_rst_data", longint'($signed(out_data)), 8);
    idle(3);

    check("final_sb_empty", sb.size(), 0);
    check("final_valid", out_valid, 0);
    check("final_ovr", overrun_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/window_accumulator.md
Name: window_accumulator

Overview:
- Downstream consumer of the sign-extended delay line.
- Takes its signed FULL_SIZE sample stream, qualified by the enable-gated valid, and sums fixed windows of ACC_LEN valid samples.
- Each window sum is scaled by an arithmetic right shift and queued in a 2-entry output buffer with a valid/ready handshake.
- The upstream stage cannot be stalled, so a full buffer drops the result and counts an overrun.

Parameters:
- IN_WIDTH, 20, input sample width (matches FULL_SIZE of the upstream stage).
- ACC_LEN, 16, samples per window; power of two, >= 2.
- SHIFT, 4, arithmetic right shift applied to the window sum; 0..log2(ACC_LEN).
- ACC_WIDTH, IN_WIDTH+$clog2(ACC_LEN), derived localparam; accumulator width, cannot overflow.
- OVR_WIDTH, 8, overrun counter width.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  IN_WIDTH  signed sample.
- in_valid  in  1  sample qualifier; no backpressure toward upstream.
- clear  in  1  synchronous window flush.
- out_data  out  ACC_WIDTH  signed scaled window sum, head of buffer.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  downstream accept.
- overrun_count  out  OVR_WIDTH  dropped results, saturating.
- busy  out  1  FSM in ACCUM.

Behaviour:
- Reset (async assert, sync-released use): FSM=IDLE, acc=0, cnt=0, buffer empty, out_valid=0, out_data=0, overrun_count=0, busy=0.
- FSM IDLE:
  - in_valid -> acc<=sign-extended in_data, cnt<=1, go ACCUM.
  - clear has priority over in_valid.
- FSM ACCUM:
  - in_valid with cnt<ACC_LEN-1 -> acc<=acc+in_data, cnt++.
  - in_valid with cnt==ACC_LEN-1 -> result=(acc+in_data)>>>SHIFT (arithmetic, floor toward -inf), push result, acc<=0, cnt<=0, go IDLE.
  - in_valid low -> hold acc and cnt; gaps are allowed and do not break the window.
- clear: acc<=0, cnt<=0, go IDLE the next cycle. The sample presented in the same cycle is discarded. Buffer and overrun_count are unaffected.
- Arithmetic: every sample is sign-extended to ACC_WIDTH. out_data is the full ACC_WIDTH value after the shift (sign-filled MSBs). No saturation is needed.
- Latency: result visible on out_data/out_valid in the cycle after the clock edge that accepts the last sample of the window, if the buffer was not full.
- Buffer: 2-entry FIFO, in-order.
  - Pop on out_valid & out_ready; out_data is stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle: allowed at any occupancy, including full (net occupancy unchanged).
  - Push while full with no pop: result dropped, overrun_count++ (saturating at all-ones), window still restarts.
- busy=1 exactly while FSM=ACCUM.
- ACC_LEN=1 and SHIFT>log2(ACC_LEN) are not supported and are guarded by an elaboration-time assertion.
- Reset mid-window: all state cleared immediately; no partial result is ever emitted.

Test Plan (ACC_LEN=4, SHIFT=2, IN_WIDTH=20, out_ready=1 unless stated):
- Samples 1,2,3,4 on consecutive cycles -> out_data=2 (10>>>2), out_valid high for exactly 1 cycle, 1 cycle after sample 4; busy high for 3 cycles.
- Samples -1,-2,-3,-4 -> out_data=-3 (floor of -2.5); samples 3,0,0,0 -> out_data=0.
- Samples 5,6,7,8 with in_valid low 2 cycles between each -> single result 6; clear asserted after the 2nd sample -> window restarts, next 4 samples 1,1,1,1 -> 1.
- out_ready=0, three full windows with sums 4,8,12 -> first two buffered, third dropped, overrun_count=1. Then out_ready=1 -> outputs 1 then 2, then out_valid=0.
- Four samples of 2^19-1 -> out_data=2^19-1 (sum 2^21-4, no overflow). Four samples of -2^19 -> out_data=-2^19.
- Reset asserted asynchronously mid-clock after 2 samples -> out_valid and busy drop immediately. Next 4 samples of value 8 -> out_data=8 (no carry-over from the earlier samples).
